// File: rtl/trng_word_packer.sv
// -----------------------------------------------------------------------------
// trng_word_packer
//
// Serial-to-parallel packer for the ring-oscillator TRNG datapath. It gathers
// one random bit per enabled clock into WIDTH-bit words and presents each
// completed word on a valid/ready output. The output has a single holding
// register.
//
// A word that completes while the holding register still holds an unconsumed
// word is dropped. The drop is counted and never disturbs the word being
// presented.
//
// Parameters
//   WIDTH      word width in bits (2..64)
//   MSB_FIRST  1: first received bit lands in word[WIDTH-1]
//              0: first received bit lands in word[0]
//   OVR_W      width of the saturating dropped-word counter
//
// Ports
//   clk_i           clock, all state on the rising edge
//   clear_n_i       asynchronous active-low reset
//   clear_i         synchronous soft clear (same effect as reset)
//   en_i            bit-valid strobe; in_i is sampled when high
//   in_i            serial random bit
//   word_ready_i    consumer accepts word_o when word_valid_o is high
//   word_o          assembled word, stable while word_valid_o is high
//   word_valid_o    holding register contains an unconsumed word
//   fill_count_o    bits collected toward the current word (0..WIDTH-1)
//   overrun_o       sticky flag, set when any word is dropped
//   overrun_cnt_o   dropped-word count, saturating
// -----------------------------------------------------------------------------
module trng_word_packer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int OVR_W     = 8
) (
    input  logic                         clk_i,
    input  logic                         clear_n_i,
    input  logic                         clear_i,
    input  logic                         en_i,
    input  logic                         in_i,
    input  logic                         word_ready_i,
    output logic [WIDTH-1:0]             word_o,
    output logic                         word_valid_o,
    output logic [$clog2(WIDTH+1)-1:0]   fill_count_o,
    output logic                         overrun_o,
    output logic [OVR_W-1:0]             overrun_cnt_o
);

    localparam int FCW = $clog2(WIDTH + 1);
    localparam logic [FCW-1:0] FILL_LAST = FCW'(WIDTH - 1);
    localparam logic [FCW-1:0] FILL_ONE  = FCW'(1);
    localparam logic [OVR_W-1:0] CNT_ONE = OVR_W'(1);

    logic [WIDTH-1:0] sr_q,    sr_d;
    logic [WIDTH-1:0] word_q,  word_d;
    logic [FCW-1:0]   fill_q,  fill_d;
    logic             valid_q, valid_d;
    logic             ovr_q,   ovr_d;
    logic [OVR_W-1:0] cnt_q,   cnt_d;

    logic [WIDTH-1:0] shifted;
    logic             complete;
    logic             load;
    logic             drop;

    // Shift direction is fixed at elaboration time.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted = {sr_q[WIDTH-2:0], in_i};
        end else begin : g_lsb_first
            assign shifted = {in_i, sr_q[WIDTH-1:1]};
        end
    endgenerate

    // The completing bit is taken straight from in_i through 'shifted', so the
    // holding register receives the full word on the same edge.
    assign complete = en_i && (fill_q == FILL_LAST);
    // The holding register is free if it is empty, or if it is being drained
    // on this very edge.
    assign load     = complete && (!valid_q || word_ready_i);
    assign drop     = complete && valid_q && !word_ready_i;

    always_comb begin
        sr_d    = sr_q;
        fill_d  = fill_q;
        word_d  = word_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            sr_d    = '0;
            fill_d  = '0;
            word_d  = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            if (en_i) begin
                // The shift register is not cleared on completion; every bit
                // is overwritten before the next word completes.
                sr_d   = shifted;
                fill_d = complete ? '0 : fill_q + FILL_ONE;
            end
            if (load) begin
                word_d  = shifted;
                valid_d = 1'b1;
            end else if (valid_q && word_ready_i) begin
                valid_d = 1'b0;
            end
            if (drop) begin
                ovr_d = 1'b1;
                if (!(&cnt_q)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            sr_q    <= '0;
            fill_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o        = word_q;
    assign word_valid_o  = valid_q;
    assign fill_count_o  = fill_q;
    assign overrun_o     = ovr_q;
    assign overrun_cnt_o = cnt_q;

endmodule

// File: tb/tb_trng_word_packer.sv
module tb_trng_word_packer;

    logic clk = 1'b0;
    logic clear_n;
    logic clr;
    logic en;
    logic din;
    logic rdy;

    logic [7:0] word_m,  word_l;
    logic       valid_m, valid_l;
    logic [3:0] fill_m,  fill_l;
    logic       ovr_m,   ovr_l;
    logic [1:0] cnt_m;
    logic [7:0] cnt_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Two instances share the stimulus: MSB-first with a 2-bit drop counter,
    // LSB-first with an 8-bit drop counter.
    trng_word_packer #(.WIDTH(8), .MSB_FIRST(1'b1), .OVR_W(2)) dut_m (
        .clk_i(clk), .clear_n_i(clear_n), .clear_i(clr), .en_i(en), .in_i(din),
        .word_ready_i(rdy), .word_o(word_m), .word_valid_o(valid_m),
        .fill_count_o(fill_m), .overrun_o(ovr_m), .overrun_cnt_o(cnt_m)
    );

    trng_word_packer #(.WIDTH(8), .MSB_FIRST(1'b0), .OVR_W(8)) dut_l (
        .clk_i(clk), .clear_n_i(clear_n), .clear_i(clr), .en_i(en), .in_i(din),
        .word_ready_i(rdy), .word_o(word_l), .word_valid_o(valid_l),
        .fill_count_o(fill_l), .overrun_o(ovr_l), .overrun_cnt_o(cnt_l)
    );

    // ---------------- reference model ----------------
    bit         mq[$];          // bits received toward the current word
    logic [7:0] mw_m, mw_l;     // held words
    logic       mv, movr;
    int         mcnt_m, mcnt_l;

    task automatic model_reset();
        mq.delete();
        mw_m = 8'h00; mw_l = 8'h00;
        mv = 1'b0; movr = 1'b0;
        mcnt_m = 0; mcnt_l = 0;
    endtask

    task automatic model_step(input logic e, input logic b, input logic r, input logic c);
        logic [7:0] wm, wl;
        logic       done;
        if (c) begin
            model_reset();
            return;
        end
        done = 1'b0;
        wm = 8'h00; wl = 8'h00;
        if (e) begin
            mq.push_back(b);
            if (mq.size() == 8) begin
                for (int i = 0; i < 8; i++) begin
                    wm = 8'((wm << 1) | 8'(mq[i]));   // first bit becomes MSB
                    wl[i] = mq[i];                   // first bit becomes LSB
                end
                mq.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!mv || r) begin
                mw_m = wm; mw_l = wl; mv = 1'b1;
            end else begin
                movr = 1'b1;
                if (mcnt_m < 3)   mcnt_m++;
                if (mcnt_l < 255) mcnt_l++;
            end
        end else if (mv && r) begin
            mv = 1'b0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("valid_m", 64'(valid_m), 64'(mv));
        chk("valid_l", 64'(valid_l), 64'(mv));
        chk("fill_m", 64'(fill_m), 64'(mq.size()));
        chk("fill_l", 64'(fill_l), 64'(mq.size()));
        chk("overrun_m", 64'(ovr_m), 64'(movr));
        chk("overrun_l", 64'(ovr_l), 64'(movr));
        chk("ovr_cnt_m", 64'(cnt_m), 64'(mcnt_m));
        chk("ovr_cnt_l", 64'(cnt_l), 64'(mcnt_l));
        if (mv) begin
            chk("word_m", 64'(word_m), 64'(mw_m));
            chk("word_l", 64'(word_l), 64'(mw_l));
        end
    endtask

    task automatic cycle(input logic e, input logic b, input logic r, input logic c);
        en = e; din = b; rdy = r; clr = c;
        @(posedge clk);
        model_step(e, b, r, c);
        #1;
        compare_all();
    endtask

    task automatic feed_word(input logic [7:0] w, input logic r);
        for (int i = 7; i >= 0; i--) cycle(1'b1, w[i], r, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       en, in, rdy, clr;
        logic       exp_valid;
        logic [3:0] exp_fill;
        logic [7:0] exp_m, exp_l;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic b, input logic r, input logic v,
                       input logic [3:0] f, input logic [7:0] m, input logic [7:0] l);
        vec_t t;
        t.en = e; t.in = b; t.rdy = r; t.clr = 1'b0;
        t.exp_valid = v; t.exp_fill = f; t.exp_m = m; t.exp_l = l;
        tbl.push_back(t);
    endtask

    initial begin
        logic [7:0] stream;
        logic [7:0] patt;
        stream = 8'b1011_0010;

        clear_n = 1'b0; clr = 1'b0; en = 1'b0; din = 1'b0; rdy = 1'b0;
        model_reset();
        #1;
        compare_all();                       // reset state, before any edge
        #20;
        clear_n = 1'b1;
        @(posedge clk); #1;
        compare_all();

        // Plain stream: B2 / 4D, valid for exactly one cycle.
        for (int i = 0; i < 8; i++)
            add(1'b1, stream[7-i], 1'b1, (i == 7), 4'((i + 1) % 8), 8'hB2, 8'h4D);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
        // Same stream with a 3-cycle en gap after bit 4.
        for (int i = 0; i < 4; i++)
            add(1'b1, stream[7-i], 1'b1, 1'b0, 4'(i + 1), 8'h00, 8'h00);
        for (int i = 0; i < 3; i++)
            add(1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 8'h00, 8'h00);
        for (int i = 4; i < 8; i++)
            add(1'b1, stream[7-i], 1'b1, (i == 7), 4'((i + 1) % 8), 8'hB2, 8'h4D);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00);

        foreach (tbl[k]) begin
            cycle(tbl[k].en, tbl[k].in, tbl[k].rdy, tbl[k].clr);
            chk("tbl_valid", 64'(valid_m), 64'(tbl[k].exp_valid));
            chk("tbl_fill", 64'(fill_m), 64'(tbl[k].exp_fill));
            if (tbl[k].exp_valid) begin
                chk("tbl_word_m", 64'(word_m), 64'(tbl[k].exp_m));
                chk("tbl_word_l", 64'(word_l), 64'(tbl[k].exp_l));
            end
        end

        // Backpressure: B2 held, 11 and 22 dropped.
        feed_word(8'hB2, 1'b0);
        feed_word(8'h11, 1'b0);
        feed_word(8'h22, 1'b0);
        chk("bp_word", 64'(word_m), 64'h B2);
        chk("bp_valid", 64'(valid_m), 64'd1);
        chk("bp_overrun", 64'(ovr_m), 64'd1);
        chk("bp_cnt", 64'(cnt_m), 64'd2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_drain", 64'(valid_m), 64'd0);

        // Consume and complete on the same edge.
        feed_word(8'hB2, 1'b0);
        patt = 8'hA5;
        for (int i = 7; i >= 1; i--) cycle(1'b1, patt[i], 1'b0, 1'b0);
        cycle(1'b1, patt[0], 1'b1, 1'b0);
        chk("cc_word", 64'(word_m), 64'h A5);
        chk("cc_valid", 64'(valid_m), 64'd1);
        chk("cc_cnt", 64'(cnt_m), 64'd2);

        // Saturation: five more drops.
        for (int w = 0; w < 5; w++) feed_word(8'(w * 37 + 3), 1'b0);
        chk("sat_cnt_m", 64'(cnt_m), 64'd3);
        chk("sat_cnt_l", 64'(cnt_l), 64'd7);
        chk("sat_word", 64'(word_m), 64'h A5);

        // Soft clear with en high after a 5-bit partial word.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_clr_fill", 64'(fill_m), 64'd5);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_fill", 64'(fill_m), 64'd0);
        chk("clr_valid", 64'(valid_m), 64'd0);
        chk("clr_cnt", 64'(cnt_m), 64'd0);
        chk("clr_overrun", 64'(ovr_m), 64'd0);

        // Asynchronous reset mid-cycle with state present.
        feed_word(8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        clear_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 64'(valid_m), 64'd0);
        chk("arst_fill", 64'(fill_m), 64'd0);
        chk("arst_word", 64'(word_m), 64'd0);
        compare_all();
        #1;
        clear_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("arst_first_bit", 64'(fill_m), 64'd1);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trng_word_packer.md
# trng_word_packer

Parametrised serial-to-parallel word packer for the ring-oscillator TRNG datapath. It collects raw or post-processed random bits, one per enabled clock, into `WIDTH`-bit words. Bit order is selectable. Completed words are presented on a valid/ready output with a one-word holding register. Words that complete while the holding register is occupied are dropped and counted, so a stalled consumer never corrupts a word already presented. It replaces the fixed 8-bit SIPO between the entropy source and the word consumer.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..64.
- `MSB_FIRST`, 1: 1 = first received bit ends in `word[WIDTH-1]`; 0 = first received bit ends in `word[0]`.
- `OVR_W`, 8: width of the dropped-word counter.
- `clk` input 1: single clock, all state on rising edge.
- `clear_n` input 1: asynchronous active-low reset; all state to reset values.
- `clear` input 1: synchronous active-high soft clear; same effect as reset on the next edge.
- `en` input 1: bit-valid strobe; `in` is sampled on edges where `en`=1.
- `in` input 1: serial random bit.
- `word_ready` input 1: consumer accepts `word` on edges where `word_valid`=1 and `word_ready`=1.
- `word` output `WIDTH`: assembled word; stable while `word_valid`=1.
- `word_valid` output 1: holding register contains an unconsumed word.
- `fill_count` output `$clog2(WIDTH+1)`: bits collected toward the current word, 0..WIDTH-1.
- `overrun` output 1: sticky; set when any word is dropped.
- `overrun_cnt` output `OVR_W`: dropped-word count, saturating at 2^OVR_W-1.

## Operation
- Reset (`clear_n`=0, asynchronous): `word`=0, `word_valid`=0, `fill_count`=0, `overrun`=0, `overrun_cnt`=0; internal shift register=0.
- `clear`=1 produces the same values on the next edge. It has priority over `en`, `in` and `word_ready`; the bit presented in that cycle is discarded.
- Shift on `en`=1:
  - `MSB_FIRST`=1: `sr <= {sr[WIDTH-2:0], in}`.
  - `MSB_FIRST`=0: `sr <= {in, sr[WIDTH-1:1]}`.
  - When `fill_count` < WIDTH-1, `fill_count` increments.
- Completion: `en`=1 while `fill_count`=WIDTH-1.
  - The assembled word includes the current `in`.
  - `fill_count` wraps to 0.
  - The shift register need not be cleared, since every bit is overwritten before the next completion.
- Holding register on completion:
  - Loaded when `word_valid`=0, or when `word_valid`=1 and `word_ready`=1 in the same cycle.
  - After a load, `word_valid`=1.
  - Otherwise the completed word is dropped: `word` and `word_valid` are unchanged, `overrun` is set, and `overrun_cnt` increments unless saturated.
- Consumption: `word_valid`=1 and `word_ready`=1 with no completion in the same cycle clears `word_valid`. `word` keeps its value but is don't-care.
- `word_ready` is ignored while `word_valid`=0.
- `en`=0: no shift, `fill_count` holds. The handshake still operates.
- Only `clear`/`clear_n` clear `overrun` and `overrun_cnt`.

## Timing
- Latency: `word_valid` rises on the edge that samples the WIDTH-th bit. It is visible in the following cycle.
- Throughput: one word per WIDTH enabled cycles.
- With `word_ready` held at 1, back-to-back words are never dropped, including when `en`=1 on every cycle.
- Consume and load in the same cycle: `word_valid` stays 1 and `word` updates to the new word; no bubble, no drop.
- `word` never changes while `word_valid`=1 and `word_ready`=0.
- `fill_count` reflects registered state: after k enabled bits it reads k mod WIDTH.
- `clear_n` asserted mid-word discards partial bits. After release, the first enabled bit counts as bit 1.

## Test plan
- WIDTH=8, MSB_FIRST=1, `word_ready`=1: bits 1,0,1,1,0,0,1,0 on consecutive cycles -> `word`=8'hB2, `word_valid` high exactly one cycle, `fill_count` returns to 0.
- WIDTH=8, MSB_FIRST=0, same stream -> `word`=8'h4D.
- Same stream with `en` low for 3 cycles after bit 4 -> `fill_count` holds at 4 during the gap; result still 8'hB2, `word_valid` rises 3 cycles later than without the gap.
- Backpressure, `word_ready`=0, feed words 8'hB2, 8'h11, 8'h22 -> `word` stays 8'hB2 with `word_valid`=1, `overrun`=1, `overrun_cnt`=2. Then assert `word_ready` for one cycle -> `word_valid`=0.
- Simultaneous consume and complete: `word_valid`=1, `word_ready`=1 on the cycle the 8th bit of 8'hA5 arrives -> next cycle `word`=8'hA5, `word_valid`=1, `overrun_cnt` unchanged.
- Saturation and clear:
  - OVR_W=2, `word_ready`=0, drop 5 words -> `overrun_cnt`=3.
  - Then `clear`=1 with `en`=1 after 5 bits of a partial word -> all outputs 0, `fill_count`=0.
  - Then pulse `clear_n` low mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
